// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver with majority-vote bit recovery, parity/stop checking
// and a first-word-fall-through RX FIFO with valid/ready drain.
module uart_rx_fifo #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 1,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rx,
  output logic [DATA_BITS-1:0]          m_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy,
  output logic                          parity_err,
  output logic                          frame_err,
  output logic                          overrun_err
);

  localparam int TICK_DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int M  = OVERSAMPLE / 2;

  localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);
  localparam logic [TW-1:0] T_LAST   = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] T_S0     = TW'(M - 1);
  localparam logic [TW-1:0] T_S1     = TW'(M);
  localparam logic [TW-1:0] T_DEC    = TW'(M + 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

  logic                 rx_s1_q, rx_s2_q, rx_prev_q;
  state_t               state_q, state_d;
  logic [DW-1:0]        div_q, div_d;
  logic [TW-1:0]        t_q, t_d;
  logic [1:0]           samp_q, samp_d;
  logic [BW-1:0]        bitn_q, bitn_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 par_q, par_d;
  logic                 stop2_q, stop2_d;
  logic                 ferr_q, ferr_d;
  logic                 busy_q, busy_d;
  logic                 pe_q, pe_d, fe_q, fe_d, ov_q, ov_d;
  logic [AW-1:0]        wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]        count_q, count_d;
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];

  logic tick, dec, adv, maj, push, pop, full, last_stop;
  logic frame_pe, frame_fe, data_x;

  assign tick = (div_q == DIV_LAST);
  assign dec  = tick && (t_q == T_DEC);
  assign adv  = tick && (t_q == T_LAST);
  // samp_q holds the samples from t = M-1 and t = M; the live rx is the third vote.
  assign maj  = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s2_q) | (samp_q[1] & rx_s2_q);
  assign pop  = (count_q != '0) && m_ready;
  assign full = (count_q == DEPTH_C);
  assign last_stop = (STOP_BITS == 1) || stop2_q;
  assign data_x    = ^shreg_q;
  assign frame_fe  = ferr_q | ~maj;
  assign frame_pe  = (PARITY == 1) ? (data_x != par_q) :
                     (PARITY == 2) ? (data_x == par_q) : 1'b0;

  // 2-flop synchroniser plus one history flop for falling-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_s1_q   <= rx;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = tick ? '0 : div_q + 1'b1;
    t_d     = t_q;
    samp_d  = samp_q;
    bitn_d  = bitn_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    stop2_d = stop2_q;
    ferr_d  = ferr_q;
    pe_d    = 1'b0;
    fe_d    = 1'b0;
    ov_d    = 1'b0;
    push    = 1'b0;

    if (tick) t_d = (t_q == T_LAST) ? '0 : t_q + 1'b1;
    if (tick && (t_q == T_S0)) samp_d[0] = rx_s2_q;
    if (tick && (t_q == T_S1)) samp_d[1] = rx_s2_q;

    case (state_q)
      S_IDLE: begin
        if (rx_prev_q && !rx_s2_q) begin
          state_d = S_START;
          div_d   = '0;
          t_d     = '0;
          bitn_d  = '0;
          stop2_d = 1'b0;
          ferr_d  = 1'b0;
        end
      end
      S_START: begin
        if (dec && maj)  state_d = S_IDLE;
        else if (adv)    state_d = S_DATA;
      end
      S_DATA: begin
        if (dec) shreg_d = {maj, shreg_q[DATA_BITS-1:1]};
        if (adv) begin
          if (bitn_q == BIT_LAST) state_d = (PARITY != 0) ? S_PAR : S_STOP;
          else                    bitn_d  = bitn_q + 1'b1;
        end
      end
      S_PAR: begin
        if (dec) par_d = maj;
        if (adv) state_d = S_STOP;
      end
      S_STOP: begin
        // Final stop bit ends at its decision tick so a back-to-back start is not missed.
        if (dec && last_stop) begin
          state_d = S_IDLE;
          pe_d    = frame_pe;
          fe_d    = frame_fe;
          if (!frame_pe && !frame_fe) begin
            if (!full || pop) push = 1'b1;
            else              ov_d = 1'b1;
          end
        end else begin
          if (dec && !maj) ferr_d  = 1'b1;
          if (adv)         stop2_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
    wr_d   = push ? wr_q + 1'b1 : wr_q;
    rd_d   = pop  ? rd_q + 1'b1 : rd_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      t_q     <= '0;
      samp_q  <= 2'b11;
      bitn_q  <= '0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      stop2_q <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
      pe_q    <= 1'b0;
      fe_q    <= 1'b0;
      ov_q    <= 1'b0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      t_q     <= t_d;
      samp_q  <= samp_d;
      bitn_q  <= bitn_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      stop2_q <= stop2_d;
      ferr_q  <= ferr_d;
      busy_q  <= busy_d;
      pe_q    <= pe_d;
      fe_q    <= fe_d;
      ov_q    <= ov_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= shreg_q;
  end

  assign m_valid     = (count_q != '0);
  assign m_data      = m_valid ? mem_q[rd_q] : '0;
  assign fifo_count  = count_q;
  assign busy        = busy_q;
  assign parity_err  = pe_q;
  assign frame_err   = fe_q;
  assign overrun_err = ov_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: default-format DUT with a queue scoreboard, plus
// odd-parity and two-stop-bit instances for the format-specific cases.
module tb_uart_rx_fifo;
  localparam int CF  = 7_372_800;
  localparam int BR  = 115200;
  localparam int OS  = 16;
  localparam int FD  = 8;
  localparam int BIT = (CF / (BR * OS)) * OS;

  logic clk = 1'b0, rst_n = 1'b0;
  logic rx0 = 1'b1, rx1 = 1'b1, rx2 = 1'b1;
  logic rdy0 = 1'b1, rdy1 = 1'b0, rdy2 = 1'b0;
  logic [7:0] md0, md1, md2;
  logic       mv0, mv1, mv2, bz0, bz1, bz2;
  logic       pe0, pe1, pe2, fe0, fe1, fe2, ov0, ov1, ov2;
  logic [3:0] fc0, fc1, fc2;

  always #5 clk = ~clk;

  uart_rx_fifo #(.CLK_FREQ(CF), .BAUD(BR), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1),
                 .OVERSAMPLE(OS), .FIFO_DEPTH(FD)) u0 (
    .clk(clk), .rst_n(rst_n), .rx(rx0), .m_data(md0), .m_valid(mv0), .m_ready(rdy0),
    .fifo_count(fc0), .busy(bz0), .parity_err(pe0), .frame_err(fe0), .overrun_err(ov0));
  uart_rx_fifo #(.CLK_FREQ(CF), .BAUD(BR), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1),
                 .OVERSAMPLE(OS), .FIFO_DEPTH(FD)) u1 (
    .clk(clk), .rst_n(rst_n), .rx(rx1), .m_data(md1), .m_valid(mv1), .m_ready(rdy1),
    .fifo_count(fc1), .busy(bz1), .parity_err(pe1), .frame_err(fe1), .overrun_err(ov1));
  uart_rx_fifo #(.CLK_FREQ(CF), .BAUD(BR), .DATA_BITS(8), .PARITY(1), .STOP_BITS(2),
                 .OVERSAMPLE(OS), .FIFO_DEPTH(FD)) u2 (
    .clk(clk), .rst_n(rst_n), .rx(rx2), .m_data(md2), .m_valid(mv2), .m_ready(rdy2),
    .fifo_count(fc2), .busy(bz2), .parity_err(pe2), .frame_err(fe2), .overrun_err(ov2));

  int n_chk = 0, n_fail = 0;
  int pe_c [3] = '{0, 0, 0};
  int fe_c [3] = '{0, 0, 0};
  int ov_c [3] = '{0, 0, 0};
  logic [7:0] exp_q [$];

  typedef struct {
    logic [7:0] d;
    logic       pb;
    logic       sb;
    logic       epe;
    logic       efe;
  } vec_t;
  vec_t tab [8];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (pe0) pe_c[0]++;
    if (pe1) pe_c[1]++;
    if (pe2) pe_c[2]++;
    if (fe0) fe_c[0]++;
    if (fe1) fe_c[1]++;
    if (fe2) fe_c[2]++;
    if (ov0) ov_c[0]++;
    if (ov1) ov_c[1]++;
    if (ov2) ov_c[2]++;
  end

  // Every word popped from the default DUT must match the model's oldest expected word.
  always @(negedge clk) begin
    if (rst_n && mv0 && rdy0) begin
      if (exp_q.size() == 0) chk("sb_extra_word", exp_q.size(), 1);
      else                   chk("sb_data", md0, exp_q.pop_front());
    end
  end

  task automatic set_rx(input int id, input logic v);
    case (id)
      0:       rx0 = v;
      1:       rx1 = v;
      default: rx2 = v;
    endcase
  endtask

  task automatic set_rdy0(input logic v);
    @(posedge clk);
    #1 rdy0 = v;
    @(negedge clk);
  endtask

  task automatic send_frame(input int id, input logic [7:0] d, input logic pb,
                            input logic s1, input logic s2, input int nstop, input int gap);
    logic [15:0] b;
    int n;
    b = '0;
    b[8:1] = d;
    b[9] = pb;
    b[10] = s1;
    b[11] = s2;
    n = 10 + nstop;
    for (int i = 0; i < n; i++) begin
      set_rx(id, b[i]);
      repeat (BIT) @(negedge clk);
    end
    set_rx(id, 1'b1);
    repeat (gap) @(negedge clk);
  endtask

  // Model: a good frame enters the FIFO unless it is full with no drain, else it overruns.
  task automatic frame0(input logic [7:0] d, input logic pb, input logic sb, input int gap,
                        output int dpe, output int dfe);
    int pe_s, fe_s, ov_s, exp_ov;
    logic ok;
    pe_s = pe_c[0]; fe_s = fe_c[0]; ov_s = ov_c[0];
    exp_ov = 0;
    ok = ((^d) == pb) && sb;
    if (ok) begin
      if (exp_q.size() < FD || rdy0) exp_q.push_back(d);
      else                           exp_ov = 1;
    end
    send_frame(0, d, pb, sb, 1'b1, 1, gap);
    dpe = pe_c[0] - pe_s;
    dfe = fe_c[0] - fe_s;
    chk("overrun_pulse", ov_c[0] - ov_s, exp_ov);
    chk("fifo_count", fc0, exp_q.size());
    chk("busy_after", bz0, 0);
  endtask

  initial begin
    int dpe, dfe, pe_s, fe_s, ov_s;
    logic [7:0] d;
    logic pb, sb;

    tab[0] = '{8'h55, 1'b0, 1'b1, 1'b0, 1'b0};
    tab[1] = '{8'hA3, 1'b1, 1'b1, 1'b1, 1'b0};
    tab[2] = '{8'h0F, 1'b0, 1'b1, 1'b0, 1'b0};
    tab[3] = '{8'h3C, 1'b0, 1'b0, 1'b0, 1'b1};
    tab[4] = '{8'h01, 1'b1, 1'b1, 1'b0, 1'b0};
    tab[5] = '{8'h80, 1'b0, 1'b1, 1'b1, 1'b0};
    tab[6] = '{8'h7E, 1'b1, 1'b0, 1'b1, 1'b1};
    tab[7] = '{8'hFF, 1'b0, 1'b1, 1'b0, 1'b0};

    repeat (3) @(negedge clk);
    chk("rst_m_data", md0, 0);
    chk("rst_m_valid", mv0, 0);
    chk("rst_fifo_count", fc0, 0);
    chk("rst_busy", bz0, 0);
    chk("rst_errs", {pe0, fe0, ov0}, 0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      frame0(tab[i].d, tab[i].pb, tab[i].sb, tab[i].sb ? 10 : 16, dpe, dfe);
      chk($sformatf("tab%0d_parity_err", i), dpe, tab[i].epe);
      chk($sformatf("tab%0d_frame_err", i), dfe, tab[i].efe);
    end

    // Short low glitch on idle line: false start, no side effects.
    pe_s = pe_c[0]; fe_s = fe_c[0]; ov_s = ov_c[0];
    rx0 = 1'b0;
    repeat (8) @(negedge clk);
    chk("glitch_busy_high", bz0, 1);
    repeat (4 * (BIT / OS) - 8) @(negedge clk);
    rx0 = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    chk("glitch_busy_low", bz0, 0);
    chk("glitch_pulses", (pe_c[0] - pe_s) + (fe_c[0] - fe_s) + (ov_c[0] - ov_s), 0);
    chk("glitch_fifo_count", fc0, 0);
    frame0(8'h0F, 1'b0, 1'b1, 10, dpe, dfe);
    chk("post_glitch_errs", dpe + dfe, 0);

    // Fill past capacity with no drain; ninth frame overruns.
    set_rdy0(1'b0);
    for (int k = 1; k <= 9; k++) begin
      d = 8'(k);
      frame0(d, ^d, 1'b1, 0, dpe, dfe);
      chk("fill_errs", dpe + dfe, 0);
    end
    chk("full_count", fc0, FD);
    chk("full_valid", mv0, 1);
    set_rdy0(1'b1);
    for (int i = 0; i < 40 && fc0 != 0; i++) @(negedge clk);
    chk("drain_count", fc0, 0);
    chk("drain_model_empty", exp_q.size(), 0);

    // Reset in the middle of data bit 4 of 0x7E.
    pe_s = pe_c[0]; fe_s = fe_c[0]; ov_s = ov_c[0];
    d = 8'h7E;
    rx0 = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx0 = d[i];
      repeat (BIT) @(negedge clk);
    end
    rx0 = d[4];
    repeat (BIT / 2) @(negedge clk);
    chk("pre_reset_busy", bz0, 1);
    rst_n = 1'b0;
    rx0 = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", bz0, 0);
    chk("mid_rst_outs", {md0, mv0, fc0, pe0, fe0, ov0}, 0);
    repeat (10) @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    chk("abort_pulses", (pe_c[0] - pe_s) + (fe_c[0] - fe_s) + (ov_c[0] - ov_s), 0);
    chk("abort_fifo_count", fc0, 0);
    frame0(8'h7E, 1'b0, 1'b1, 10, dpe, dfe);
    chk("post_reset_errs", dpe + dfe, 0);

    // Line break: one framing error, then silence until rx returns high.
    pe_s = pe_c[0]; fe_s = fe_c[0];
    rx0 = 1'b0;
    repeat (14 * BIT) @(negedge clk);
    chk("break_frame_err", fe_c[0] - fe_s, 1);
    chk("break_parity_err", pe_c[0] - pe_s, 0);
    chk("break_busy", bz0, 0);
    chk("break_fifo_count", fc0, 0);
    rx0 = 1'b1;
    repeat (BIT) @(negedge clk);
    frame0(8'hC5, 1'b0, 1'b1, 10, dpe, dfe);
    chk("post_break_errs", dpe + dfe, 0);

    // Random frames with random drain pressure.
    for (int i = 0; i < 14; i++) begin
      set_rdy0(1'($urandom_range(0, 1)));
      d  = 8'($urandom_range(0, 255));
      pb = ($urandom_range(0, 3) == 0) ? ~(^d) : (^d);
      sb = ($urandom_range(0, 5) != 0);
      frame0(d, pb, sb, sb ? $urandom_range(0, 20) : 4 + $urandom_range(0, 20), dpe, dfe);
      chk("rnd_parity_err", dpe, int'((^d) != pb));
      chk("rnd_frame_err", dfe, int'(!sb));
    end
    set_rdy0(1'b1);
    for (int i = 0; i < 40 && fc0 != 0; i++) @(negedge clk);
    chk("rnd_drain_count", fc0, 0);

    // Odd parity instance.
    send_frame(1, 8'hA3, 1'b1, 1'b1, 1'b1, 1, 10);
    chk("odd_valid", mv1, 1);
    chk("odd_data", md1, 8'hA3);
    chk("odd_no_perr", pe_c[1], 0);
    send_frame(1, 8'h55, 1'b0, 1'b1, 1'b1, 1, 10);
    chk("odd_perr", pe_c[1], 1);
    chk("odd_count", fc1, 1);
    @(posedge clk);
    #1 rdy1 = 1'b1;
    @(posedge clk);
    #1 rdy1 = 1'b0;
    @(negedge clk);
    chk("odd_pop_count", fc1, 0);
    chk("odd_pop_valid", mv1, 0);

    // Two-stop-bit instance.
    send_frame(2, 8'h3C, 1'b0, 1'b1, 1'b0, 2, 10);
    chk("stop2_second_low", fe_c[2], 1);
    chk("stop2_no_write", fc2, 0);
    send_frame(2, 8'h3C, 1'b0, 1'b0, 1'b1, 2, 10);
    chk("stop2_first_low", fe_c[2], 2);
    send_frame(2, 8'h3C, 1'b0, 1'b1, 1'b1, 2, 10);
    chk("stop2_good_data", md2, 8'h3C);
    chk("stop2_good_count", fc2, 1);
    chk("stop2_perr", pe_c[2], 0);

    chk("sb_leftover", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Parametrised next-generation UART receiver for the AXI-to-UART path.
- Adds oversampled majority-vote bit recovery, false-start rejection, runtime-independent parity (none/even/odd), 1 or 2 stop bits, and framing, parity and overrun error reporting.
- Received words are buffered in a first-word-fall-through FIFO with a valid/ready output handshake toward the AXI-side register logic.

Parameters:
- CLK_FREQ, 50_000_000: system clock frequency in Hz.
- BAUD, 115200: line baud rate.
- DATA_BITS, 8: data bits per frame; legal range 5..9.
- PARITY, 1: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1: 1 or 2.
- OVERSAMPLE, 16: ticks per bit; even, at least 8.
- FIFO_DEPTH, 8: RX FIFO entries; power of 2, at least 2.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rx  in  1  UART serial input, idle high, asynchronous to clk.
- m_data  out  DATA_BITS  FIFO head word.
- m_valid  out  1  FIFO non-empty.
- m_ready  in  1  consumer accepts m_data when m_valid && m_ready.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy, 0..FIFO_DEPTH.
- busy  out  1  high whenever the FSM is not in IDLE.
- parity_err  out  1  one-clk pulse: received parity mismatched.
- frame_err  out  1  one-clk pulse: a stop bit was sampled low.
- overrun_err  out  1  one-clk pulse: good frame dropped because FIFO full.

Behaviour:
- Reset: while rst_n is low, every output is 0 (m_data, m_valid, fifo_count, busy, all error pulses). FSM goes to IDLE, FIFO is emptied, synchroniser flops are set to 1. Asserting reset mid-frame discards the partial frame with no error pulse.
- rx passes through a 2-flop synchroniser; all references to rx below mean the synchronised value.
- Tick generator:
  - TICK_DIV = CLK_FREQ/(BAUD*OVERSAMPLE), integer truncation; must be at least 2. Default gives 27.
  - One-clk tick every TICK_DIV clocks.
  - Tick counter and divider are both cleared on start detection so the frame is phase-aligned.
- Sampling within each bit period, tick index t = 0..OVERSAMPLE-1:
  - Samples are taken at t = M-1, M and M+1, where M = OVERSAMPLE/2.
  - Bit value is the majority of the 3 samples, decided at t = M+1.
  - The FSM advances at t = OVERSAMPLE-1, except for the last stop bit.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: a 1->0 transition of rx goes to START.
  - START: if the majority is 1, this is a false start; return to IDLE with no pulse and no FIFO write. If the majority is 0, go to DATA at the end of the bit.
  - DATA: DATA_BITS bits, LSB first, shifted into the shift register. After the last bit, go to PARITY if PARITY != 0, else STOP.
  - PARITY: capture the parity bit.
    - Even parity: the check passes when the XOR of the data bits equals the captured bit.
    - Odd parity: the check passes when the XOR of the data bits is not equal to the captured bit.
  - STOP: each stop-bit majority must be 1, else the frame error flag is set. With STOP_BITS = 2 the first stop bit runs a full period. The final stop bit is completed at its decision tick (t = M+1); the FSM returns to IDLE there so a back-to-back start edge is caught.
- Frame completion, on the clk of the final stop-bit decision:
  - Parity mismatch: pulse parity_err.
  - Any stop bit sampled low: pulse frame_err. Both pulses may fire together.
  - Either error: the word is discarded.
  - Otherwise, if the FIFO is not full, or a pop occurs in the same clk, the word is pushed.
  - Otherwise the word is dropped and overrun_err is pulsed; the FIFO contents are unchanged.
- FIFO:
  - First-word-fall-through. A pushed word appears on m_data with m_valid = 1 on the clk after the push.
  - A pop occurs on any clk with m_valid && m_ready; m_data shows the next entry on the following clk.
  - A simultaneous push and pop leaves fifo_count unchanged.
  - Read and write pointers wrap modulo FIFO_DEPTH.
  - m_valid = (fifo_count != 0). m_ready while empty has no effect.
  - When FIFO_DEPTH words are stored, fifo_count = FIFO_DEPTH.
- Line break (rx held low): behaves as a start bit, then data 0 and a frame_err pulse. No new frame starts until rx returns high, because IDLE requires a fresh falling edge.

Test Plan:
- Default parameters, send 0x55 with even parity bit 0 and one stop bit, m_ready = 1 -> m_valid rises one clk after the stop decision, m_data = 0x55, no error pulses, busy low afterwards.
- Send 0xA3 with parity bit 1 under PARITY = 1 -> exactly one parity_err pulse, fifo_count stays 0. Same frame under PARITY = 2 -> accepted, m_data = 0xA3.
- Low glitch of 4 OVERSAMPLE ticks on idle rx -> returns to IDLE, no pulses, fifo_count = 0. Then a valid 0x0F frame -> received correctly.
- Frame 0x3C with stop bit driven 0 -> frame_err pulse, no FIFO write. Repeat with STOP_BITS = 2 and only the second stop bit low -> frame_err pulse.
- m_ready = 0, send 9 back-to-back frames 0x01..0x09 (FIFO_DEPTH = 8) -> fifo_count = 8 and one overrun_err pulse on the 9th frame. Draining returns 0x01..0x08 in order, pointers wrap correctly, final fifo_count = 0.
- Assert rst_n low during DATA bit 4 of a frame, then release and send 0x7E -> outputs all 0 during reset, no pulse for the aborted frame, and 0x7E is received cleanly.
